// File: rtl/spm_operand_sequencer_pkg.sv
// Shared definitions for the serial-parallel multiplier operand sequencer:
// default widths/limits and the sequencer FSM state encoding.
package spm_operand_sequencer_pkg;

    localparam int unsigned SpmWidth        = 8;
    localparam int unsigned SpmFifoDepth    = 4;
    localparam int unsigned SpmTimeout      = 15;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StBusy  = 2'd2
    } spm_state_e;

    // Width of a counter that must be able to hold the value n.
    function automatic int unsigned spm_cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spm_operand_sequencer_fifo.sv
// Synchronous FIFO holding {a,b} operand pairs; exposes the head word,
// full/empty flags and an occupancy count.
module spm_operand_sequencer_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_eff;
    logic             pop_eff;

    assign full_o   = (count_q == CntW'(Depth));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign rdata_o  = mem_q[rd_ptr_q];

    // A push while full is dropped; the producer is expected to hold it.
    assign push_eff = push_i && !full_o;
    assign pop_eff  = pop_i && !empty_o;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(push_eff) - CntW'(pop_eff);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_eff) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/spm_operand_sequencer.sv
// Operand sequencer for the serial-parallel multiplier: buffers operand pairs,
// issues one multiply at a time and returns signed products in order.
module spm_operand_sequencer
    import spm_operand_sequencer_pkg::*;
#(
    parameter int unsigned Width     = SpmWidth,
    parameter int unsigned FifoDepth = SpmFifoDepth,
    parameter int unsigned Timeout   = SpmTimeout
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [Width-1:0]     in_a_i,
    input  logic [Width-1:0]     in_b_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*Width-1:0]   out_product_o,
    output logic                 mul_start_o,
    output logic [Width-1:0]     mul_multiplicand_o,
    output logic [Width-1:0]     mul_multiplier_o,
    input  logic [2*Width-1:0]   mul_product_i,
    input  logic                 mul_done_i,
    output logic                 busy_o,
    output logic                 timeout_err_o
);

    localparam int unsigned CntW = $clog2(FifoDepth) + 1;
    localparam int unsigned TmoW = spm_cnt_width(Timeout);

    spm_state_e          state_q, state_d;
    logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [2*Width-1:0]  product_q, product_d;
    logic                timeout_err_q, timeout_err_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [CntW-1:0]     fifo_count;
    logic [2*Width-1:0]  fifo_head;

    spm_operand_sequencer_fifo #(
        .Width (2 * Width),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid_i),
        .wdata_i ({in_a_i, in_b_i}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign in_ready_o         = !fifo_full;
    assign mul_multiplicand_o = fifo_head[2*Width-1:Width];
    assign mul_multiplier_o   = fifo_head[Width-1:0];
    assign out_valid_o        = out_valid_q;
    assign out_product_o      = product_q;
    assign timeout_err_o      = timeout_err_q;
    assign busy_o             = (state_q != StIdle) || (fifo_count != '0);

    always_comb begin
        state_d       = state_q;
        tmo_cnt_d     = tmo_cnt_q;
        out_valid_d   = out_valid_q;
        product_d     = product_q;
        timeout_err_d = timeout_err_q;
        mul_start_o   = 1'b0;
        fifo_pop      = 1'b0;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                // Registered out_valid gates issue, keeping one result in flight.
                if (!fifo_empty && !out_valid_q) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mul_start_o = 1'b1;
                fifo_pop    = 1'b1;
                tmo_cnt_d   = '0;
                state_d     = StBusy;
            end
            StBusy: begin
                // mul_done seen in the first BUSY cycle may belong to the previous op.
                if ((tmo_cnt_q != '0) && mul_done_i) begin
                    product_d   = mul_product_i;
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end else if (tmo_cnt_q == TmoW'(Timeout - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            tmo_cnt_q     <= '0;
            out_valid_q   <= 1'b0;
            product_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_cnt_q     <= tmo_cnt_d;
            out_valid_q   <= out_valid_d;
            product_q     <= product_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_spm_operand_sequencer.sv
// Randomised bench for spm_operand_sequencer with a behavioural 8-cycle multiplier
// and an in-order scoreboard of accepted operand pairs.
module tb_spm_operand_sequencer;

    localparam int MulLatency = 8;
    localparam int TimeoutCyc = 15;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        mul_start;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_product;
    logic        mul_done;
    logic        busy;
    logic        timeout_err;

    spm_operand_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .in_a_i             (in_a),
        .in_b_i             (in_b),
        .out_valid_o        (out_valid),
        .out_ready_i        (out_ready),
        .out_product_o      (out_product),
        .mul_start_o        (mul_start),
        .mul_multiplicand_o (mul_a),
        .mul_multiplier_o   (mul_b),
        .mul_product_i      (mul_product),
        .mul_done_i         (mul_done),
        .busy_o             (busy),
        .timeout_err_o      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_bad     = 0;
    int n_pushed  = 0;
    int n_res     = 0;
    int n_dropped = 0;
    int n_flushed = 0;
    int ready_mode = 0;  // 0: hold low, 1: always high, 2: random
    logic stub_mode = 1'b0;
    logic prev_start = 1'b0;
    logic [15:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_product(input logic [15:0] ab);
        int sa;
        int sb;
        sa = $signed(ab[15:8]);
        sb = $signed(ab[7:0]);
        return 16'(sa * sb);
    endfunction

    // Stand-in for the real multiplier: done clears on start, rises 8 edges later.
    int          mul_cnt;
    logic [15:0] mul_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_done    <= 1'b0;
            mul_product <= '0;
            mul_cnt     <= 0;
            mul_res     <= '0;
        end else if (mul_start) begin
            mul_done <= 1'b0;
            mul_cnt  <= MulLatency;
            mul_res  <= $signed({{8{mul_a[7]}}, mul_a}) * $signed({{8{mul_b[7]}}, mul_b});
        end else if (mul_cnt != 0) begin
            mul_cnt <= mul_cnt - 1;
            if (mul_cnt == 1 && !stub_mode) begin
                mul_done    <= 1'b1;
                mul_product <= mul_res;
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = 1'b1;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Issue and result monitor against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (mul_start) begin
                check_eq("start_len", 32'(prev_start), 32'd0);
                check_eq("start_outv", 32'(out_valid), 32'd0);
                check_eq("start_ops", {16'h0, mul_a, mul_b},
                         (exp_q.size() > 0) ? {16'h0, exp_q[0]} : 32'hdead_beef);
            end
            if (out_valid && out_ready) begin
                check_eq("result", {16'h0, out_product},
                         (exp_q.size() > 0) ? {16'h0, ref_product(exp_q[0])} : 32'hdead_beef);
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                end
                n_res++;
            end
            prev_start = mul_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic push_op(input logic [7:0] a, input logic [7:0] b);
        logic acc;
        logic done;
        int   waited;
        acc    = 1'b0;
        done   = 1'b0;
        waited = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!done) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
            if (acc) begin
                done = 1'b1;
            end else if (waited > 500) begin
                check_eq("push_stall", 32'(acc), 32'd1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (acc) begin
            exp_q.push_back({a, b});
            n_pushed++;
        end
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || out_valid) && cyc < bound) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int edges;
        int cyc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_start", 32'(mul_start), 32'd0);
        check_eq("rst_tmo", 32'(timeout_err), 32'd0);
        check_eq("rst_prod", 32'(out_product), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single op latency; result left unconsumed for the hold test.
        push_op(8'd3, 8'hFB);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'd11);
        check_eq("t1_prod", {16'h0, out_product}, 32'h0000_FFF1);

        // Fill the FIFO behind the pending result.
        push_op(8'd7, 8'd9);
        push_op(8'hF8, 8'hF8);
        push_op(8'd127, 8'h80);
        check_eq("ready_3", 32'(in_ready), 32'd1);
        push_op(8'd0, 8'd55);
        check_eq("ready_full", 32'(in_ready), 32'd0);
        fork
            push_op(8'hFD, 8'd100);
        join_none

        repeat (30) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_prod", {16'h0, out_product}, 32'h0000_FFF1);
            check_eq("hold_start", 32'(mul_start), 32'd0);
            check_eq("hold_ready", 32'(in_ready), 32'd0);
        end

        ready_mode = 1;
        cyc = 0;
        while (n_pushed < 6 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("full_push", 32'(n_pushed), 32'd6);
        wait_drain("drain_burst", 400);
        check_eq("burst_count", 32'(n_res), 32'd6);

        // Multiplier that never answers.
        check_eq("tmo_before", 32'(timeout_err), 32'd0);
        stub_mode = 1'b1;
        push_op(8'd5, 8'd6);
        cyc = 0;
        @(negedge clk);
        while (!mul_start && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("tmo_start", 32'(mul_start), 32'd1);
        edges = 0;
        while (!timeout_err && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_eq("tmo_cycles", 32'(edges - 1), 32'(TimeoutCyc));
        check_eq("tmo_idle", 32'(busy), 32'd0);
        check_eq("tmo_outv", 32'(out_valid), 32'd0);
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            n_dropped++;
        end
        stub_mode = 1'b0;
        push_op(8'hF9, 8'd11);
        wait_drain("drain_tmo", 100);
        check_eq("tmo_sticky", 32'(timeout_err), 32'd1);

        // Asynchronous reset in the middle of a BUSY op with more queued.
        push_op(8'd10, 8'd20);
        push_op(8'd30, 8'd40);
        push_op(8'd50, 8'd60);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_outv", 32'(out_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_tmo", 32'(timeout_err), 32'd0);
        n_flushed += exp_q.size();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_op(8'hFF, 8'hFF);
        wait_drain("drain_post_rst", 100);

        // Random traffic with random backpressure.
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            push_op(8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain("drain_rand", 3000);
        check_eq("res_count", 32'(n_res), 32'(n_pushed - n_dropped - n_flushed));
        check_eq("end_tmo", 32'(timeout_err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
